gf180mcu_fd_sc_mcu7t5v0__dbnc_2: RTL



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__dbnc_2_if.sv | 19 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__dbnc_2.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbnc_2_if.sv
// Debounce cell signal bundle: raw level and enable in, filtered level and status out.
// RISE/FALL exist only with GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_EN.
// No flow control: levels only.
interface gf180mcu_fd_sc_mcu7t5v0__dbnc_2_if;
    logic I;
    logic EN;
    logic Z;
    logic BUSY;
`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_EN
    logic RISE;
    logic FALL;

    modport master (output I, output EN, input Z, input BUSY, input RISE, input FALL);
    modport slave  (input I, input EN, output Z, output BUSY, output RISE, output FALL);
`else
    modport master (output I, output EN, input Z, input BUSY);
    modport slave  (input I, input EN, output Z, output BUSY);
`endif
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbnc_2.sv
// Synchronise-then-debounce cell; macros: GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_EN, USE_POWER_PINS, FUNCTIONAL.
// Latency: SYNC_STAGES + STABLE_CNT rising edges from a stable input to Z.
// No backpressure: EN=0 freezes the filter while the synchroniser keeps shifting.
module gf180mcu_fd_sc_mcu7t5v0__dbnc_2_core #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 4,
    parameter int   STABLE_CNT  = 8,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RN,
    input  logic I,
    input  logic EN,
    output logic Z,
    output logic BUSY
`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_EN
    ,
    output logic RISE,
    output logic FALL
`endif
);
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (STABLE_CNT < 1 || STABLE_CNT > (2 ** CNT_W) - 1) begin : g_bad_cnt
        $error("STABLE_CNT must be in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   z_q, z_d;
    logic                   busy_q, busy_d;
    logic                   s;

    // Pure shift chain: nothing combinational between stages.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], I};
        s      = sync_q[SYNC_STAGES-1];
    end

    // State register: stability counter and committed level.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            cnt_q  <= '0;
            z_q    <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
        end
    end

    // Next state: a difference that disappears before the last count is dropped.
    always_comb begin
        cnt_d = cnt_q;
        z_d   = z_q;
        if (EN) begin
            if (s == z_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                z_d   = s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Outputs are registered copies of next-state conditions so they align with cnt_q/z_q.
    always_comb begin
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign Z    = z_q;
    assign BUSY = busy_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        rise_d = ~z_q & z_d;
        fall_d = z_q & ~z_d;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign RISE = rise_q;
    assign FALL = fall_q;
`endif

`ifndef FUNCTIONAL
    // I is asynchronous by nature, so it carries no timing check.
    specify
        (CLK => Z) = (0, 0);
        (CLK => BUSY) = (0, 0);
        (RN => Z) = (0, 0);
        $setuphold(posedge CLK, EN, 0, 0);
    endspecify
`endif
endmodule

// Cell top: scalar clock/reset plus the signal bundle.
module gf180mcu_fd_sc_mcu7t5v0__dbnc_2 #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 4,
    parameter int   STABLE_CNT  = 8,
    parameter logic RST_VAL     = 1'b0
) (
`ifdef USE_POWER_PINS
    inout  wire  VDD,
    inout  wire  VSS,
`endif
    input  logic CLK,
    input  logic RN,
    gf180mcu_fd_sc_mcu7t5v0__dbnc_2_if.slave bus
);
    gf180mcu_fd_sc_mcu7t5v0__dbnc_2_core #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .STABLE_CNT  (STABLE_CNT),
        .RST_VAL     (RST_VAL)
    ) u_core (
        .CLK  (CLK),
        .RN   (RN),
        .I    (bus.I),
        .EN   (bus.EN),
        .Z    (bus.Z),
        .BUSY (bus.BUSY)
`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_EN
        ,
        .RISE (bus.RISE),
        .FALL (bus.FALL)
`endif
    );
endmodule
